lc3_mc_ctrl: RTL

Parametrised multicycle control unit for the PUnC LC-3 processor. It replaces the fixed-latency controller with a variable-latency memory handshake (req/ack), a bounded wait watchdog, a retired-instruction counter and an optional TRAP sequence. It sits between the instruction register, flags and memory port on one side and the datapath muxes and load enables on the other, and it drives every datapath control line.

---
 rtl/lc3_mc_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_mc_ctrl.sv
// Multicycle LC-3 control unit with req/ack memory handshake, wait watchdog and retire counter.
// Optional TRAP sequencing is enabled by defining LC3_TRAP_EN.
module lc3_mc_ctrl #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      ir,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [1:0]       mem_addr_sel,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             pc_clr,
    output logic             mar_ld,
    output logic [1:0]       pc_sel,
    output logic             pc_off_sel,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [2:0]       rf_waddr,
    output logic [2:0]       rf_raddr0,
    output logic [2:0]       rf_raddr1,
    output logic [15:0]      sext_data,
    output logic             a_sel,
    output logic             b_sel,
    output logic [1:0]       alu_op,
    output logic             nzp_ld,
    output logic             nzp_sel,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

    localparam logic [3:0] OpBr  = 4'b0000, OpAdd = 4'b0001, OpLd  = 4'b0010, OpSt  = 4'b0011;
    localparam logic [3:0] OpJsr = 4'b0100, OpAnd = 4'b0101, OpLdr = 4'b0110, OpStr = 4'b0111;
    localparam logic [3:0] OpRti = 4'b1000, OpNot = 4'b1001, OpLdi = 4'b1010, OpSti = 4'b1011;
    localparam logic [3:0] OpJmp = 4'b1100, OpRes = 4'b1101, OpLea = 4'b1110, OpTrap = 4'b1111;

    typedef enum logic [2:0] {StFetch, StDecode, StExec1, StExec2, StHalt} state_t;

    state_t            state_q;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  instret_q;
    logic              fault_q;

    logic [3:0]  opcode;
    logic [15:0] imm5, off6, off9;
    logic        is_mem1, is_ind, is_trap, mem_state, mem_stall, mem_timeout;

    assign opcode = ir[15:12];
    assign imm5   = {{11{ir[4]}}, ir[4:0]};
    assign off6   = {{10{ir[5]}}, ir[5:0]};
    assign off9   = {{7{ir[8]}}, ir[8:0]};

    assign is_mem1 = (opcode == OpLd) || (opcode == OpLdr) || (opcode == OpSt) ||
                     (opcode == OpStr) || (opcode == OpLdi) || (opcode == OpSti);
    assign is_ind  = (opcode == OpLdi) || (opcode == OpSti);
`ifdef LC3_TRAP_EN
    assign is_trap = (opcode == OpTrap) && (ir[7:0] != 8'h25);
`else
    assign is_trap = 1'b0;
`endif

    assign mem_state   = (state_q == StFetch) || (state_q == StExec2) ||
                         ((state_q == StExec1) && is_mem1);
    assign mem_stall   = mem_state && !mem_ack && (wait_q != WAIT_W'(MAX_WAIT));
    assign mem_timeout = mem_state && !mem_ack && (wait_q == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            instret_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            // Counter runs only while a request is stalled; any state change clears it.
            wait_q <= mem_stall ? wait_q + 1'b1 : '0;
            if (mem_timeout) begin
                state_q <= StHalt;
                fault_q <= 1'b1;
            end else if (!mem_stall) begin
                case (state_q)
                    StFetch:  state_q <= StDecode;
                    StDecode: begin
                        if (opcode == OpRti || opcode == OpRes) begin
                            state_q <= StHalt;
                            fault_q <= 1'b1;
                        end else if (opcode == OpTrap && !is_trap) begin
                            state_q <= StHalt;
                        end else begin
                            state_q <= StExec1;
                        end
                    end
                    StExec1: begin
                        if (is_ind || is_trap) begin
                            state_q <= StExec2;
                        end else begin
                            state_q   <= StFetch;
                            instret_q <= instret_q + 1'b1;
                        end
                    end
                    StExec2: begin
                        state_q   <= StFetch;
                        instret_q <= instret_q + 1'b1;
                    end
                    default: state_q <= StHalt;
                endcase
            end
        end
    end

    always_comb begin
        mem_req = 1'b0; mem_we = 1'b0; mem_addr_sel = 2'd0; ir_ld = 1'b0; pc_inc = 1'b0;
        pc_ld = 1'b0; mar_ld = 1'b0; pc_sel = 2'd0; pc_off_sel = 1'b0; rf_we = 1'b0;
        rf_wsel = 2'd0; rf_waddr = 3'd0; rf_raddr0 = 3'd0; rf_raddr1 = 3'd0; sext_data = '0;
        a_sel = 1'b0; b_sel = 1'b0; alu_op = 2'd0; nzp_ld = 1'b0; nzp_sel = 1'b0;
        pc_clr = rst;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    ir_ld   = mem_ack;
                end
                StDecode: pc_inc = 1'b1;
                StExec1: begin
                    case (opcode)
                        OpAdd, OpAnd, OpNot: begin
                            rf_we     = 1'b1;
                            rf_wsel   = 2'd2;
                            rf_waddr  = ir[11:9];
                            rf_raddr0 = ir[8:6];
                            rf_raddr1 = ir[2:0];
                            nzp_ld    = 1'b1;
                            if (opcode == OpNot) begin
                                alu_op = 2'd3;
                            end else begin
                                alu_op    = (opcode == OpAnd) ? 2'd1 : 2'd0;
                                b_sel     = ir[5];
                                sext_data = imm5;
                            end
                        end
                        OpLea: begin
                            rf_we     = 1'b1;
                            rf_wsel   = 2'd2;
                            rf_waddr  = ir[11:9];
                            a_sel     = 1'b1;
                            b_sel     = 1'b1;
                            sext_data = off9;
                        end
                        OpBr: begin
                            pc_ld      = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
                            pc_off_sel = 1'b1;
                            sext_data  = off9;
                        end
                        OpJmp: begin
                            pc_ld     = 1'b1;
                            pc_sel    = 2'd1;
                            rf_raddr0 = ir[8:6];
                            alu_op    = 2'd2;
                        end
                        OpJsr: begin
                            rf_we     = 1'b1;
                            rf_waddr  = 3'd7;
                            pc_ld     = 1'b1;
                            pc_sel    = ir[11] ? 2'd0 : 2'd1;
                            rf_raddr0 = ir[8:6];
                            alu_op    = 2'd2;
                        end
                        OpLd, OpLdr, OpSt, OpStr, OpLdi, OpSti: begin
                            mem_req      = 1'b1;
                            mem_addr_sel = 2'd1;
                            b_sel        = 1'b1;
                            if (opcode == OpLdr || opcode == OpStr) begin
                                rf_raddr0 = ir[8:6];
                                sext_data = off6;
                            end else begin
                                a_sel     = 1'b1;
                                sext_data = off9;
                            end
                            if (opcode == OpLd || opcode == OpLdr) begin
                                rf_we    = mem_ack;
                                rf_wsel  = 2'd1;
                                rf_waddr = ir[11:9];
                                nzp_ld   = mem_ack;
                                nzp_sel  = 1'b1;
                            end else if (opcode == OpSt || opcode == OpStr) begin
                                rf_raddr1 = ir[11:9];
                                mem_we    = mem_ack;
                            end else begin
                                mar_ld = mem_ack;
                            end
                        end
`ifdef LC3_TRAP_EN
                        OpTrap: begin
                            rf_we    = is_trap;
                            rf_waddr = 3'd7;
                        end
`endif
                        default: ;
                    endcase
                end
                StExec2: begin
                    mem_req = 1'b1;
`ifdef LC3_TRAP_EN
                    if (is_trap) begin
                        mem_addr_sel = 2'd3;
                        sext_data    = {8'h00, ir[7:0]};
                        pc_ld        = mem_ack;
                        pc_sel       = 2'd2;
                    end else
`endif
                    begin
                        mem_addr_sel = 2'd2;
                        if (opcode == OpLdi) begin
                            rf_we    = mem_ack;
                            rf_wsel  = 2'd1;
                            rf_waddr = ir[11:9];
                            nzp_ld   = mem_ack;
                            nzp_sel  = 1'b1;
                        end else begin
                            rf_raddr1 = ir[11:9];
                            mem_we    = mem_ack;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted  = !rst && (state_q == StHalt);
    assign fault   = !rst && fault_q;
    assign instret = rst ? '0 : instret_q;

endmodule
